// File: rtl/timer_pkg.sv
// Shared definitions for the counter_ctrl timer block.
// Holds the FSM state encoding, the default maximum prescaler exponent,
// and a helper that clamps a requested exponent to the legal range.
package timer_pkg;

    localparam int DIV_VAL_MAX = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Clamp a requested prescaler exponent to the largest supported value.
    function automatic logic [3:0] sat_div_val(input logic [3:0] div_val,
                                               input logic [3:0] max_val);
        logic [3:0] result;
        if (div_val > max_val) begin
            result = max_val;
        end else begin
            result = div_val;
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: counts cycles while running and emits a tick every
// 2^div_val cycles (every cycle when disabled or div_val is 0).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : high in COUNT; the divider advances
//   hold       : high in HALTED; the divider freezes
//   div_en     : prescaler enable
//   div_val    : exponent, clamped to DIV_MAX
//   tick       : combinational count-enable for the main counter
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       hold,
    input  logic       div_en,
    input  logic [3:0] div_val,
    output logic       tick
);

    localparam int CW = (DIV_MAX < 1) ? 1 : DIV_MAX;

    logic [3:0]    div_eff_s;
    logic [CW-1:0] term_s;
    logic          wrap_s;
    logic [CW-1:0] div_cnt_r;

    // Terminal count is a mask of div_eff low ones, i.e. 2^div_eff - 1.
    always_comb begin
        div_eff_s = sat_div_val(div_val, 4'(DIV_MAX));
        term_s    = '0;
        for (int i = 0; i < CW; i++) begin
            term_s[i] = (i < int'(div_eff_s));
        end
        wrap_s = (div_cnt_r == term_s);
    end

    // Divider counter: advance in COUNT, freeze in HALTED, clear otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
        end else if (run) begin
            if (wrap_s) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + CW'(1);
            end
        end else if (hold) begin
            div_cnt_r <= div_cnt_r;
        end else begin
            div_cnt_r <= '0;
        end
    end

    // Tick only while running; an undivided clock ticks every cycle.
    always_comb begin
        if (run) begin
            tick = !div_en || (div_eff_s == 4'd0) || wrap_s;
        end else begin
            tick = 1'b0;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// 64-bit timer with prescaler, debug halt, software load/clear and a sticky
// compare-match interrupt.
// Ports:
//   sys_clk, sys_rst_n          : clock, asynchronous active-low reset
//   timer_en, div_en, div_val   : counting enable, prescaler enable/exponent
//   halt_req, dbg_mode          : debug halt request and its qualifier
//   compare_val                 : 64-bit compare value
//   interrupt_en                : gates interrupt_status onto tim_int
//   counter_clear               : clears cnt_val (highest priority)
//   counter_write_sel/_data     : per-half load of cnt_val
//   interrupt_clear             : clears interrupt_status (a new match wins)
//   cnt_val, halt_ack_status, interrupt_status : registered outputs
//   tim_int                     : interrupt line
module counter_ctrl
    import timer_pkg::*;
#(
    parameter int DIV_VAL_MAX = timer_pkg::DIV_VAL_MAX
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        timer_en,
    input  logic        div_en,
    input  logic [3:0]  div_val,
    input  logic        halt_req,
    input  logic        dbg_mode,
    input  logic [63:0] compare_val,
    input  logic        interrupt_en,
    input  logic        counter_clear,
    input  logic [1:0]  counter_write_sel,
    input  logic [31:0] counter_write_data,
    input  logic        interrupt_clear,
    output logic [63:0] cnt_val,
    output logic        halt_ack_status,
    output logic        interrupt_status,
    output logic        tim_int
);

    state_t state_r;
    state_t state_next_s;
    logic   halt_cond_s;
    logic   run_s;
    logic   hold_s;
    logic   tick_s;
    logic   match_s;

    assign halt_cond_s = halt_req && dbg_mode;

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a qualified halt request overrides everything.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (halt_cond_s) begin
                    state_next_s = HALTED;
                end else if (timer_en) begin
                    state_next_s = COUNT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COUNT: begin
                if (halt_cond_s) begin
                    state_next_s = HALTED;
                end else if (!timer_en) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = COUNT;
                end
            end
            HALTED: begin
                if (halt_cond_s) begin
                    state_next_s = HALTED;
                end else if (timer_en) begin
                    state_next_s = COUNT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM output decode driving the prescaler.
    always_comb begin
        run_s  = 1'b0;
        hold_s = 1'b0;
        case (state_r)
            COUNT:   run_s  = 1'b1;
            HALTED:  hold_s = 1'b1;
            default: begin
                run_s  = 1'b0;
                hold_s = 1'b0;
            end
        endcase
    end

    // Halt acknowledge registered from the next state so it tracks state_r.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            halt_ack_status <= 1'b0;
        end else begin
            halt_ack_status <= (state_next_s == HALTED);
        end
    end

    timer_prescaler #(
        .DIV_MAX (DIV_VAL_MAX)
    ) u_prescaler (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .run     (run_s),
        .hold    (hold_s),
        .div_en  (div_en),
        .div_val (div_val),
        .tick    (tick_s)
    );

    // Main counter: clear, then software load (which suppresses the tick), then tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_val <= 64'd0;
        end else if (counter_clear) begin
            cnt_val <= 64'd0;
        end else if (counter_write_sel != 2'b00) begin
            if (counter_write_sel[0]) begin
                cnt_val[31:0] <= counter_write_data;
            end else begin
                cnt_val[31:0] <= cnt_val[31:0];
            end
            if (counter_write_sel[1]) begin
                cnt_val[63:32] <= counter_write_data;
            end else begin
                cnt_val[63:32] <= cnt_val[63:32];
            end
        end else if (tick_s) begin
            cnt_val <= cnt_val + 64'd1;
        end else begin
            cnt_val <= cnt_val;
        end
    end

    assign match_s = (cnt_val == compare_val);

    // Sticky match flag; a match in the same cycle as a clear keeps it set.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            interrupt_status <= 1'b0;
        end else if (match_s) begin
            interrupt_status <= 1'b1;
        end else if (interrupt_clear) begin
            interrupt_status <= 1'b0;
        end else begin
            interrupt_status <= interrupt_status;
        end
    end

    assign tim_int = interrupt_status && interrupt_en;

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have one parameter: DIV_VAL_MAX, default 8, the largest legal divider exponent.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- sys_clk  in  1  system clock; all state updates on its rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- timer_en  in  1  counting enable.
- div_en  in  1  prescaler enable.
- div_val  in  4  prescaler exponent; tick period is 2^div_val cycles.
- halt_req  in  1  debug halt request.
- dbg_mode  in  1  debug mode qualifier for halt_req.
- compare_val  in  64  compare value.
- interrupt_en  in  1  interrupt output enable.
- counter_clear  in  1  single-cycle clear pulse.
- counter_write_sel  in  2  bit0 loads cnt[31:0], bit1 loads cnt[63:32].
- counter_write_data  in  32  load data.
- interrupt_clear  in  1  clears interrupt_status.
- cnt_val  out  64  counter value, registered.
- halt_ack_status  out  1  high while halted.
- interrupt_status  out  1  sticky compare-match flag.
- tim_int  out  1  interrupt line.

Function
REQ-003 The FSM SHALL have three states: IDLE, COUNT and HALTED; it resets to IDLE.
REQ-004 IDLE->COUNT: timer_en=1 and not (halt_req and dbg_mode).
REQ-005 COUNT->IDLE: timer_en=0.
REQ-006 Transition to HALTED:
- IDLE or COUNT -> HALTED when halt_req=1 and dbg_mode=1.
- This transition has priority over all other transitions.
REQ-007 HALTED exit: when halt_req=0 or dbg_mode=0, the FSM goes to COUNT if timer_en=1, otherwise to IDLE.
REQ-008 halt_ack_status SHALL equal (state==HALTED) and be registered, so it asserts 1 cycle after the halt condition is sampled.
REQ-009 Prescaler counter div_cnt:
- Cleared to 0 in IDLE.
- Holds its value in HALTED.
- In COUNT, increments each cycle and wraps to 0 after reaching 2^div_val-1.
REQ-010 Tick generation in COUNT:
- tick=1 every cycle when div_en=0 or div_val=0.
- Otherwise tick=1 when div_cnt == 2^div_val-1.
- tick is 0 in all other states.
REQ-011 div_val > DIV_VAL_MAX SHALL be saturated to DIV_VAL_MAX.
REQ-012 cnt_val priority per cycle, highest first:
- counter_clear: cnt_val <= 0.
- Any counter_write_sel bit set: the selected half or halves load counter_write_data; the other half holds; no increment that cycle.
- tick: cnt_val <= cnt_val+1.
- Otherwise: hold.
REQ-013 Counter writes SHALL be accepted in every state, including HALTED and IDLE.
REQ-014 Increment SHALL be full 64-bit modulo 2^64; FFFF_FFFF_FFFF_FFFF -> 0 with no flag.
REQ-015 Match SHALL be (cnt_val == compare_val), evaluated on registered cnt_val in every state; on a match, interrupt_status is set on the next edge.
REQ-016 interrupt_clear SHALL clear interrupt_status; if set and clear occur in the same cycle, set wins.
REQ-017 tim_int SHALL equal interrupt_status AND interrupt_en (combinational).
REQ-018 counter_clear SHALL NOT clear interrupt_status or the FSM state.

Reset
REQ-019 On sys_rst_n=0, asynchronously:
- cnt_val=0, div_cnt=0, state=IDLE.
- interrupt_status=0, halt_ack_status=0, tim_int=0.
REQ-020 Reset asserted mid-count or mid-halt SHALL discard all progress; after deassertion the block behaves as from power-up.

Structure
REQ-021 Package timer_pkg SHALL hold the state encodings (IDLE=2'd0, COUNT=2'd1, HALTED=2'd2) and DIV_VAL_MAX.
REQ-022 The prescaler (div_cnt and tick) SHALL be the sub-module timer_prescaler, with inputs run, hold, div_en and div_val and output tick.
REQ-023 counter_ctrl SHALL contain the FSM, the 64-bit counter, the comparator and the interrupt flag.

Verification
REQ-024 div_en=0, timer_en=1 for 10 cycles -> cnt_val=10; then timer_en=0 -> cnt_val holds at 10 and state=IDLE.
REQ-025 div_en=1, div_val=2, timer_en=1 for 16 cycles -> cnt_val=4, incrementing every 4th cycle.
REQ-026 counter_write_sel=2'b11 with data 32'hFFFF_FFFF (two writes giving all-ones), then 1 tick -> cnt_val=0 and no flag.
REQ-027 compare_val=5, interrupt_en=1, counting -> interrupt_status=1 and tim_int=1 one cycle after cnt_val=5; interrupt_clear in the same cycle as a set -> stays 1; clear later -> 0.
REQ-028 Halt sequence:
- During counting at cnt_val=7, set halt_req=1 and dbg_mode=1 -> halt_ack_status=1 next cycle, cnt_val frozen at 7 or 8, div_cnt frozen.
- Set halt_req=0 -> counting resumes from the frozen div_cnt.
REQ-029 Priority and reset checks:
- counter_clear and counter_write_sel=2'b01 in the same cycle -> cnt_val=0.
- sys_rst_n pulsed low while HALTED -> all outputs 0 and state=IDLE.
